// File: rtl/dsp_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dsp_seq_pkg
// Description : Shared types and constants for the dot-product sequencer.
//               Contains the controller state encoding, the per-slot control
//               tag and the pipeline latency of the downstream DSP slice.
// Revision    : 1.0 - initial release
// ============================================================================
package dsp_seq_pkg;

    // Cycles from operands on the slice ports to the cycle the slice's
    // multiply/accumulate select applies to them.
    localparam int PIPE_LAT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE0 = 2'd3
    } state_t;

    // Control tag that travels alongside each operand slot.
    typedef struct packed {
        logic mul;
        logic acc;
        logic last;
    } slot_tag_t;

endpackage
`default_nettype wire

// File: rtl/dsp_slot_pipe.sv
`default_nettype none
// ============================================================================
// Module      : dsp_slot_pipe
// Description : DEPTH-deep shift register carrying slot tags so that the
//               slice's multiply/accumulate selects line up with the operands
//               they refer to inside the slice pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_slot_pipe
    import dsp_seq_pkg::*;
#(
    parameter int DEPTH = PIPE_LAT
) (
    input  logic      clk,
    input  logic      reset,
    input  slot_tag_t tag_in,
    output slot_tag_t tag_out
);

    slot_tag_t stages [DEPTH];

    // Shift tags one stage per cycle; reset flushes every stage to idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign tag_out = stages[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/dsp_dot_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dsp_dot_sequencer
// Description : Dot-product controller in front of the int8/16-bit DSP slice.
//               Accepts a length command and a stream of operand pairs, issues
//               one slot per cycle to the slice with multiply/accumulate
//               selects delayed to match the slice pipeline, and returns the
//               wrapped sum through a one-deep valid/ready output register.
//               Optional macro DOT_SEQ_PERF_EN adds the perf_bubbles counter.
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_dot_sequencer #(
    parameter int DWIDTH   = 16,
    parameter int LEN_W    = 8,
    parameter int PIPE_LAT = dsp_seq_pkg::PIPE_LAT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [DWIDTH-1:0] op_a,
    input  logic [DWIDTH-1:0] op_b,
    output logic [DWIDTH-1:0] dsp_ax,
    output logic [DWIDTH-1:0] dsp_ay,
    output logic [DWIDTH-1:0] dsp_az,
    output logic              dsp_multiply,
    output logic              dsp_accumulate,
    input  logic [DWIDTH-1:0] dsp_result,
`ifdef DOT_SEQ_PERF_EN
    output logic [31:0]       perf_bubbles,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data
);

    import dsp_seq_pkg::*;

    state_t            state, state_nxt;
    logic [LEN_W-1:0]  remaining, remaining_nxt;
    logic              first_done, first_done_nxt;
    logic              last_seen, last_seen_nxt;
    slot_tag_t         slot_tag, slot_tag_nxt;
    slot_tag_t         pipe_out;
    logic [DWIDTH-1:0] ay_nxt, az_nxt, out_data_nxt;
    logic              cmd_ready_nxt, op_ready_nxt, out_valid_nxt;
    logic              cmd_fire, op_fire;

    assign cmd_fire = cmd_valid & cmd_ready;
    assign op_fire  = op_valid & op_ready;

    // The addend port is unused: the slice computes ay*az (+ accumulator).
    assign dsp_ax = '0;

    // Tags leave the pipe exactly when the slice applies them to their slot.
    dsp_slot_pipe #(
        .DEPTH (PIPE_LAT)
    ) u_slot_pipe (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (slot_tag),
        .tag_out (pipe_out)
    );

    assign dsp_multiply   = pipe_out.mul;
    assign dsp_accumulate = pipe_out.acc;

    // Next-state, slot generation and output-register decisions.
    always_comb begin
        state_nxt      = state;
        remaining_nxt  = remaining;
        first_done_nxt = first_done;
        last_seen_nxt  = last_seen;
        slot_tag_nxt   = '0;
        ay_nxt         = '0;
        az_nxt         = '0;
        out_valid_nxt  = out_valid & ~out_ready;
        out_data_nxt   = out_data;

        case (state)
            IDLE: begin
                if (cmd_fire) begin
                    remaining_nxt  = cmd_len;
                    first_done_nxt = 1'b0;
                    last_seen_nxt  = 1'b0;
                    if (cmd_len == '0) begin
                        // Empty vector: result is known immediately.
                        state_nxt     = DONE0;
                        out_valid_nxt = 1'b1;
                        out_data_nxt  = '0;
                    end else begin
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // Before the first real pair the slice loads; afterwards it adds.
                slot_tag_nxt.mul = ~first_done;
                slot_tag_nxt.acc = first_done;
                if (op_fire) begin
                    ay_nxt         = op_a;
                    az_nxt         = op_b;
                    first_done_nxt = 1'b1;
                    remaining_nxt  = remaining - LEN_W'(1);
                    if (remaining == LEN_W'(1)) begin
                        slot_tag_nxt.last = 1'b1;
                        state_nxt         = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Last tag applied one cycle ago -> dsp_result now final.
                if (last_seen) begin
                    out_data_nxt  = dsp_result;
                    out_valid_nxt = 1'b1;
                    last_seen_nxt = 1'b0;
                    state_nxt     = IDLE;
                end else if (pipe_out.last) begin
                    last_seen_nxt = 1'b1;
                end
            end
            DONE0: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        cmd_ready_nxt = (state_nxt == IDLE) && !out_valid_nxt;
        op_ready_nxt  = (state_nxt == ISSUE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            remaining  <= '0;
            first_done <= 1'b0;
            last_seen  <= 1'b0;
            slot_tag   <= '0;
            dsp_ay     <= '0;
            dsp_az     <= '0;
            cmd_ready  <= 1'b0;
            op_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            state      <= state_nxt;
            remaining  <= remaining_nxt;
            first_done <= first_done_nxt;
            last_seen  <= last_seen_nxt;
            slot_tag   <= slot_tag_nxt;
            dsp_ay     <= ay_nxt;
            dsp_az     <= az_nxt;
            cmd_ready  <= cmd_ready_nxt;
            op_ready   <= op_ready_nxt;
            out_valid  <= out_valid_nxt;
            out_data   <= out_data_nxt;
        end
    end

`ifdef DOT_SEQ_PERF_EN
    // Count ISSUE slots that carried no operand pair; sticks at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_bubbles <= '0;
        end else if (state == ISSUE && !op_valid && perf_bubbles != '1) begin
            perf_bubbles <= perf_bubbles + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire
